// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   tx_state_t      : frame sequencer state encoding (IDLE/START/DATA/STOP)
//   UART_FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   UART_DATA_W     : data bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_W     = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Free-running bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the
// last clock of each serial bit.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-low reset
//   clear    in  restart the period at count 0 on the next edge
//   bit_done out high during the last clock of a bit period
// ---------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bit_done = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Pops bytes from a first-word-fall-through TX FIFO and serialises each one
// as an 8N1 frame (start, 8 data bits LSB first, stop), every bit held for
// CLKS_PER_BIT clocks. Back-to-back frames run with no idle gap.
// Ports:
//   clk         in  system clock (rising edge)
//   rst         in  asynchronous active-low reset
//   tx_en       in  permission to start new frames
//   fifo_empty  in  TX FIFO empty flag
//   fifo_dout   in  TX FIFO head word (valid while fifo_empty=0)
//   fifo_rd_en  out pop strobe, combinational
//   tx          out registered serial line, idle high
//   busy        out high while a frame is in flight
//   frame_done  out one-cycle pulse on the last clock of each stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [1:0] S_IDLE  = TX_IDLE;
    localparam logic [1:0] S_START = TX_START;
    localparam logic [1:0] S_DATA  = TX_DATA;
    localparam logic [1:0] S_STOP  = TX_STOP;

    // Bit counter values: 0 = start, 1..DATA_W = data, FRAME_BITS-1 = stop.
    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_W);
    localparam logic [3:0] STOP_IDX      = 4'(UART_FRAME_BITS - 1);

    logic [1:0]        state_reg,   state_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_W-1:0] shreg_reg,   shreg_next;
    logic              tx_reg,      tx_next;
    logic [DATA_W-1:0] shreg_shifted;
    logic              bit_done;
    logic              pop;
    logic              baud_clear;

    // Baud timer is held at zero while idle and restarted on every pop, so
    // the start bit always lasts a full period measured from the pop edge.
    assign baud_clear = pop || (state_reg == S_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    // A new frame may start from idle, or on the final stop-bit clock so the
    // next start bit follows without a gap.
    assign pop = tx_en && !fifo_empty &&
                 ((state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_done));

    // Logical shift right by one, MSB filled with zero.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W - 1; gi++) begin : g_shift
            assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
    endgenerate
    assign shreg_shifted[DATA_W-1] = 1'b0;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        tx_next      = tx_reg;

        if (pop) begin
            state_next   = S_START;
            bit_cnt_next = 4'd0;
            shreg_next   = fifo_dout;
            tx_next      = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    tx_next      = 1'b1;
                    bit_cnt_next = 4'd0;
                end
                S_START: begin
                    if (bit_done) begin
                        state_next   = S_DATA;
                        bit_cnt_next = 4'd1;
                        tx_next      = shreg_reg[0];
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt_reg == LAST_DATA_IDX) begin
                            state_next   = S_STOP;
                            bit_cnt_next = STOP_IDX;
                            tx_next      = 1'b1;
                        end else begin
                            shreg_next   = shreg_shifted;
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                            tx_next      = shreg_shifted[0];
                        end
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        state_next   = S_IDLE;
                        bit_cnt_next = 4'd0;
                        tx_next      = 1'b1;
                    end
                end
                default: begin
                    state_next   = S_IDLE;
                    bit_cnt_next = 4'd0;
                    tx_next      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= 4'd0;
            shreg_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            tx_reg      <= tx_next;
        end
    end

    assign fifo_rd_en = pop;
    assign tx         = tx_reg;
    assign busy       = (state_reg != S_IDLE);
    assign frame_done = (state_reg == S_STOP) && bit_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=16. A queue models the
// FWFT TX FIFO; per-clock samples of the outputs are recorded relative to
// the pop edge (index k = clock k after the pop edge) and checked against
// hand-computed frames.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    int n_assert  = 0;
    int n_fail    = 0;
    int underflow = 0;

    logic tx_tr   [0:511];
    logic busy_tr [0:511];
    logic fd_tr   [0:511];
    logic rd_tr   [0:511];

    // Expected line levels per frame bit, index 0 = start bit.
    logic [0:9]  exp_a5 = 10'b0101001011;
    logic [0:19] exp_b  = 20'b0000000001_0111111111;
    logic [0:9]  exp_11 = 10'b0100010001;
    logic [0:9]  exp_3c = 10'b0001111001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fifo_drive();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_drive();
    endtask

    // Sample the current clock period into slot k, then cross the next edge.
    task automatic step(input int k);
        @(negedge clk);
        tx_tr[k]   = tx;
        busy_tr[k] = busy;
        fd_tr[k]   = frame_done;
        rd_tr[k]   = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd_tr[k] === 1'b1) begin
            if (q.size() == 0) underflow++;
            else void'(q.pop_front());
        end
        fifo_drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(k);
    endtask

    // sel: 0 = rd high, 1 = frame_done high, 2 = tx low, 3 = busy high
    function automatic int count_sel(input int sel, input int from, input int to);
        int c = 0;
        for (int i = from; i <= to; i++) begin
            case (sel)
                0: if (rd_tr[i] === 1'b1) c++;
                1: if (fd_tr[i] === 1'b1) c++;
                2: if (tx_tr[i] !== 1'b1) c++;
                default: if (busy_tr[i] === 1'b1) c++;
            endcase
        end
        return c;
    endfunction

    function automatic int first_fd(input int from, input int to);
        for (int i = from; i <= to; i++) if (fd_tr[i] === 1'b1) return i;
        return -1;
    endfunction

    // Line level held across one bit period, or 2 if it was not steady.
    function automatic logic [31:0] bit_seen(input int base);
        logic v = tx_tr[base];
        if (v !== 1'b0 && v !== 1'b1) return 2;
        for (int i = 1; i < CPB; i++) if (tx_tr[base+i] !== v) return 2;
        return {31'd0, v};
    endfunction

    initial begin
        rst   = 1'b1;
        tx_en = 1'b0;
        fifo_drive();

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset fifo_rd_en", fifo_rd_en, 0);
        chk("reset frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Single byte 0xA5.
        tx_en = 1'b1;
        push(8'hA5);
        step(511);
        chk("A5 pop strobe", rd_tr[511], 1);
        run(170);
        for (int i = 0; i < 10; i++) chk($sformatf("A5 bit%0d", i), bit_seen(16 * i), exp_a5[i]);
        chk("A5 frame_done pos", first_fd(0, 169), 159);
        chk("A5 frame_done cnt", count_sel(1, 0, 169), 1);
        chk("A5 busy last clk", busy_tr[159], 1);
        chk("A5 busy after", busy_tr[160], 0);
        chk("A5 idle tx", tx_tr[169], 1);
        chk("A5 extra pops", count_sel(0, 0, 169), 0);

        // Back-to-back 0x00, 0xFF.
        push(8'h00);
        push(8'hFF);
        step(511);
        chk("B2B pop strobe", rd_tr[511], 1);
        run(330);
        for (int i = 0; i < 20; i++) chk($sformatf("B2B bit%0d", i), bit_seen(16 * i), exp_b[i]);
        chk("B2B second pop clk159", rd_tr[159], 1);
        chk("B2B pop cnt", count_sel(0, 0, 329), 1);
        chk("B2B fd cnt", count_sel(1, 0, 329), 2);
        chk("B2B fd 159", fd_tr[159], 1);
        chk("B2B fd 319", fd_tr[319], 1);
        chk("B2B busy contiguous", count_sel(3, 0, 319), 320);
        chk("B2B busy after", busy_tr[320], 0);

        // tx_en low with data waiting, then dropped during frame bit 3.
        tx_en = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        run(100);
        chk("EN0 no pop", count_sel(0, 0, 99), 0);
        chk("EN0 tx idle", count_sel(2, 0, 99), 0);
        chk("EN0 not busy", count_sel(3, 0, 99), 0);
        tx_en = 1'b1;
        step(511);
        chk("EN1 pop strobe", rd_tr[511], 1);
        for (int k = 0; k < 170; k++) begin
            if (k == 50) tx_en = 1'b0;
            step(k);
        end
        for (int i = 0; i < 10; i++) chk($sformatf("EN 11 bit%0d", i), bit_seen(16 * i), exp_11[i]);
        chk("EN no 2nd pop", count_sel(0, 0, 169), 0);
        chk("EN fd 159", fd_tr[159], 1);
        chk("EN busy after", busy_tr[160], 0);
        chk("EN fifo left", q.size(), 2);
        q.delete();
        fifo_drive();

        // Enabled but empty FIFO.
        tx_en = 1'b1;
        run(200);
        chk("EMPTY no pop", count_sel(0, 0, 199), 0);
        chk("EMPTY tx idle", count_sel(2, 0, 199), 0);
        push(8'h3C);
        step(511);
        chk("3C pop strobe", rd_tr[511], 1);
        run(85);
        for (int i = 0; i < 5; i++) chk($sformatf("3C bit%0d", i), bit_seen(16 * i), exp_3c[i]);
        chk("3C tx clk84", tx_tr[84], exp_3c[5]);
        chk("3C busy clk84", busy_tr[84], 1);

        // Reset in the middle of data bit 4.
        #2 rst = 1'b0;
        #1;
        chk("midrst tx", tx, 1);
        chk("midrst busy", busy, 0);
        chk("midrst frame_done", frame_done, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        run(50);
        chk("postrst busy", count_sel(3, 0, 49), 0);
        chk("postrst no pop", count_sel(0, 0, 49), 0);
        chk("postrst tx idle", count_sel(2, 0, 49), 0);
        push(8'h5A);
        step(511);
        chk("5A pop strobe", rd_tr[511], 1);
        run(161);
        chk("5A start tx", tx_tr[0], 0);
        chk("5A busy", busy_tr[0], 1);
        chk("5A fd pos", first_fd(0, 160), 159);
        chk("5A busy after", busy_tr[160], 0);

        chk("no underflow", underflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one 8N1 frame at a time out of the TX FIFO onto the serial line. It pops a byte when the FIFO is non-empty and transmit is enabled, then drives start, 8 data bits (LSB first) and stop, each held for `CLKS_PER_BIT` clocks. It sits between the TX FIFO read port and the `tx` pad, and owns the baud timing and the 10-bit frame counting.

## Interface
- `CLKS_PER_BIT`, 16, clocks per serial bit; legal range ≥ 2.
- `DATA_W`, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `tx_en`  in  1  permission to start new frames.
- `fifo_empty`  in  1  TX FIFO empty flag.
- `fifo_dout`  in  8  TX FIFO head word; first-word-fall-through, valid whenever `fifo_empty`=0.
- `fifo_rd_en`  out  1  pop strobe; the FIFO advances on the clock edge where this is high.
- `tx`  out  1  serial line, registered; idle high.
- `busy`  out  1  high while a frame is in progress (START, DATA or STOP).
- `frame_done`  out  1  one-cycle pulse on the last clock of each stop bit.

## Operation
- States are IDLE, START, DATA and STOP.
- Internal counters:
  - Baud counter runs 0..`CLKS_PER_BIT`-1 and asserts `bit_done` at `CLKS_PER_BIT`-1.
  - Bit counter is 4-bit and runs 0..9. It is 0 in START, 1–8 in DATA and 9 in STOP.
- Pop condition: `pop = tx_en & ~fifo_empty & (state==IDLE | (state==STOP & bit_done))`.
- `fifo_rd_en = pop`, generated combinationally. This is the only path that pops the FIFO.
- On a `pop` edge:
  - the shift register loads `fifo_dout`;
  - state goes to START and `tx` goes to 0;
  - the baud counter and bit counter clear.
- START ends on `bit_done`; state goes to DATA and `tx` is driven to `shreg[0]`.
- DATA: on each `bit_done`, shift right and drive the next bit. After the 8th data bit, state goes to STOP and `tx` goes to 1.
- STOP ends on `bit_done`:
  - `frame_done` pulses;
  - if `pop`, go to START (back-to-back, no idle gap);
  - otherwise go to IDLE.
- Boundary conditions:
  - `fifo_empty`=1 in IDLE: no pop, stay in IDLE (no underflow ever).
  - `tx_en` deasserted mid-frame: the current frame completes, and no further pop occurs.
  - `tx_en` or `fifo_empty` changing while not at a pop point has no effect.
  - Reset mid-frame: the in-flight byte is discarded. It is not re-read, because it was already popped.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0. State, counters and shift register are all 0.
- `tx` falls on the same edge that pops the FIFO.
- Frame length is exactly 10×`CLKS_PER_BIT` clocks.
- `frame_done` is high during clock 10×`CLKS_PER_BIT`−1 after the pop edge.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit clock.
- `busy` is 1 from the pop edge until the edge that returns the block to IDLE.

## Structure
- Package `uart_pkg` holds:
  - state enum typedef `tx_state_t`;
  - constants `UART_FRAME_BITS`=10 and `UART_DATA_W`=8.
- One sub-module, `uart_baud_counter`:
  - inputs: `clk`, `rst`, `clear`;
  - output: `bit_done`;
  - parameter: `CLKS_PER_BIT`.
- Frame sequencing, the bit counter and the shift register stay in `uart_tx_ctrl`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Reset: `rst`=0 asynchronously -> `tx`=1, `busy`=0, `fifo_rd_en`=0, `frame_done`=0 with no clock edge required.
- Single byte 0xA5 with `tx_en`=1 -> exactly one pop. `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each held 16 clocks. `frame_done` is high in clock 159. Return to IDLE with `tx`=1.
- Back-to-back 0x00 then 0xFF -> two pops, 320 contiguous clocks, no high gap between stop and the second start. Two `frame_done` pulses at clocks 159 and 319.
- `tx_en`=0 with FIFO holding 3 bytes -> no pop for 100 clocks. Then set `tx_en`=1, and drop it during bit 3 of frame 1 -> frame 1 completes, one pop total.
- `tx_en`=1, FIFO empty for 200 clocks -> `fifo_rd_en` never asserts and `tx` stays 1. Load 0x3C -> pop on the next edge.
- Reset asserted during data bit 4 -> `tx`=1 and `busy`=0 immediately. After release, the block stays in IDLE until the next pop condition.
